// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet port receiver and transmitter.
// Holds the packet-word layout {end, start, data[31:0]}, the transmitter
// state encoding and a helper that sizes the inter-packet-gap counter.
package eth_pkg;

  localparam int DATA_W    = 32;
  localparam int WORD_W    = 34;
  localparam int END_BIT   = 33;
  localparam int START_BIT = 32;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    GAP
  } tx_states;

  // Width of a counter that must hold values 0..ipg; never narrower than 1.
  function automatic int gap_cnt_w(input int ipg);
    int w;
    w = $clog2(ipg + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/eth_tx_gap_timer.sv
// eth_tx_gap_timer: loadable down-counter that times the inter-packet gap.
// Ports:
//   clk     clock
//   rstn    asynchronous reset, active low (counter clears to 0)
//   load_i  load IPG_CYCLES-1 this cycle (entry into the gap)
//   done_o  counter currently reads 0
module eth_tx_gap_timer
  import eth_pkg::*;
#(
  parameter int IPG_CYCLES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  output logic done_o
);

  localparam int CNT_W = gap_cnt_w(IPG_CYCLES);
  // With no gap configured the timer is never loaded; keep the constant legal.
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (IPG_CYCLES > 0) ? CNT_W'(IPG_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/eth_tx.sv
// eth_tx: Ethernet egress port. Drains a first-word-fall-through FIFO of
// {end, start, data} words onto a framed output port, enforcing a minimum
// idle gap between packets, resynchronising on framing errors and counting
// completed packets.
// Ports:
//   clk        clock
//   rstn       asynchronous reset, active low
//   rd_data    FIFO head word, valid whenever empty=0
//   empty      FIFO empty
//   rd_en      pop FIFO head this cycle (combinational)
//   o_data     output data (0 when o_valid=0)
//   o_valid    o_data/o_start/o_end valid
//   o_start    first word of packet
//   o_end      last word of packet
//   o_err      one-cycle pulse on a framing error
//   o_pkt_cnt  packets completed, wraps at 16 bits
module eth_tx
  import eth_pkg::*;
#(
  parameter int IPG_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_start,
  output logic              o_end,
  output logic              o_err,
  output logic [15:0]       o_pkt_cnt
);

  tx_states          state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic     pop;
  logic     emit;
  logic     gap_load;
  logic     gap_done;
  logic     head_start;
  logic     head_end;
  tx_states after_end;

  assign head_start = rd_data[START_BIT];
  assign head_end   = rd_data[END_BIT];
  // With no gap configured the next packet may follow immediately.
  assign after_end  = (IPG_CYCLES == 0) ? IDLE : GAP;

  eth_tx_gap_timer #(
    .IPG_CYCLES(IPG_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rstn  (rstn),
    .load_i(gap_load),
    .done_o(gap_done)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    emit     = 1'b0;
    gap_load = 1'b0;
    data_d   = '0;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_start) begin
            emit = 1'b1;
          end else begin
            // Word outside any packet: drop it and wait for the next start.
            err_d = 1'b1;
          end
        end
      end
      TX: begin
        if (!empty) begin
          pop  = 1'b1;
          emit = 1'b1;
          // A start here means the previous packet never ended; it is
          // abandoned uncounted and this word opens a fresh packet.
          err_d = head_start;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      valid_d = 1'b1;
      data_d  = rd_data[DATA_W-1:0];
      start_d = head_start;
      end_d   = head_end;
      if (head_end) begin
        cnt_d    = cnt_q + 16'd1;
        state_d  = after_end;
        gap_load = (after_end == GAP);
      end else begin
        state_d = TX;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held low during reset so no word is popped while it could not be emitted.
  assign rd_en     = pop & rstn;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_start   = start_q;
  assign o_end     = end_q;
  assign o_err     = err_q;
  assign o_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_eth_tx.sv
`timescale 1ns/1ps
module tb_eth_tx;

  localparam int IPG_A = 2;
  localparam int IPG_B = 0;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [33:0] rd_data   [2];
  logic        empty     [2];
  logic        rd_en     [2];
  logic [31:0] o_data    [2];
  logic        o_valid   [2];
  logic        o_start   [2];
  logic        o_end     [2];
  logic        o_err     [2];
  logic [15:0] o_pkt_cnt [2];

  always #5 clk = ~clk;

  eth_tx #(.IPG_CYCLES(IPG_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .rd_data(rd_data[0]), .empty(empty[0]),
    .rd_en(rd_en[0]), .o_data(o_data[0]), .o_valid(o_valid[0]),
    .o_start(o_start[0]), .o_end(o_end[0]), .o_err(o_err[0]),
    .o_pkt_cnt(o_pkt_cnt[0])
  );

  eth_tx #(.IPG_CYCLES(IPG_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .rd_data(rd_data[1]), .empty(empty[1]),
    .rd_en(rd_en[1]), .o_data(o_data[1]), .o_valid(o_valid[1]),
    .o_start(o_start[1]), .o_end(o_end[1]), .o_err(o_err[1]),
    .o_pkt_cnt(o_pkt_cnt[1])
  );

  int tests = 0;
  int fails = 0;

  // FIFO contents, observed output words/times, and model expectations.
  logic [33:0] fifo_a[$], fifo_b[$];
  logic [33:0] outq_a[$], outq_b[$];
  time         outt_a[$], outt_b[$];
  logic [33:0] expq_a[$], expq_b[$];

  bit          in_pkt   [2];
  logic [15:0] exp_cnt  [2];
  int          exp_err  [2];
  int          err_seen [2];
  int          since_end[2];
  bit          have_end [2];

  function automatic logic [33:0] mkw(input bit e, input bit s, input logic [31:0] d);
    return {e, s, d};
  endfunction

  function automatic void refresh();
    empty[0]   = (fifo_a.size() == 0);
    rd_data[0] = empty[0] ? 34'd0 : fifo_a[0];
    empty[1]   = (fifo_b.size() == 0);
    rd_data[1] = empty[1] ? 34'd0 : fifo_b[0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet-level model: words outside a packet are dropped with an error,
  // a start inside a packet is an error but still opens a new packet, every
  // emitted word reappears unchanged, and each end completes one packet.
  task automatic model_word(input int i, input logic [33:0] w);
    bit s, e;
    s = w[32];
    e = w[33];
    if (!in_pkt[i] && !s) begin
      exp_err[i]++;
    end else begin
      if (in_pkt[i] && s) exp_err[i]++;
      if (i == 0) expq_a.push_back(w); else expq_b.push_back(w);
      if (e) begin
        exp_cnt[i] = exp_cnt[i] + 16'd1;
        in_pkt[i]  = 1'b0;
      end else begin
        in_pkt[i] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      in_pkt[i]  = 1'b0;
      exp_cnt[i] = 16'd0;
    end
  endtask

  task automatic push(input int i, input logic [33:0] w);
    if (i == 0) fifo_a.push_back(w); else fifo_b.push_back(w);
    model_word(i, w);
    refresh();
  endtask

  function automatic time out_time(input int i, input int k);
    if (i == 0) return (k < outt_a.size()) ? outt_a[k] : 0;
    return (k < outt_b.size()) ? outt_b[k] : 0;
  endfunction

  // FIFO pops on the active edge; head/empty update shortly after.
  always @(posedge clk) begin
    logic [33:0] tmp;
    if (rd_en[0] === 1'b1 && fifo_a.size() > 0) tmp = fifo_a.pop_front();
    if (rd_en[1] === 1'b1 && fifo_b.size() > 0) tmp = fifo_b.pop_front();
    #1 refresh();
  end

  task automatic mon(input int i, input int ipg);
    logic [33:0] rec;
    rec = {o_end[i], o_start[i], o_data[i]};
    if (o_valid[i] === 1'b1) begin
      if (i == 0) begin outq_a.push_back(rec); outt_a.push_back($time); end
      else begin outq_b.push_back(rec); outt_b.push_back($time); end
    end else begin
      tests++;
      assert (rec === 34'd0) else begin
        fails++;
        $error("FAIL idle_outputs_zero[%0d]: got %h expected 0", i, rec);
      end
    end
    tests++;
    assert ((rd_en[i] & empty[i]) === 1'b0) else begin
      fails++;
      $error("FAIL pop_when_empty[%0d]: got rd_en=%b empty=%b expected no pop", i, rd_en[i], empty[i]);
    end
    if (o_err[i] === 1'b1) err_seen[i]++;
    if (!rstn) begin
      have_end[i] = 1'b0;
    end else begin
      if (o_valid[i] === 1'b1 && o_start[i] === 1'b1 && have_end[i]) begin
        tests++;
        assert (since_end[i] >= ipg) else begin
          fails++;
          $error("FAIL ipg_min[%0d]: got %0d idle cycles expected >= %0d", i, since_end[i], ipg);
        end
      end
      if (o_valid[i] === 1'b1 && o_end[i] === 1'b1) begin
        since_end[i] = 0;
        have_end[i]  = 1'b1;
      end else begin
        since_end[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, IPG_A);
    mon(1, IPG_B);
  end

  task automatic drain(input int i, input int limit);
    int n;
    n = 0;
    while (((i == 0) ? fifo_a.size() : fifo_b.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 64'(n < limit), 64'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_streams(input int i, input string tag);
    logic [33:0] oq[$], eq[$];
    int n;
    if (i == 0) begin
      oq = outq_a; eq = expq_a;
      outq_a.delete(); outt_a.delete(); expq_a.delete();
    end else begin
      oq = outq_b; eq = expq_b;
      outq_b.delete(); outt_b.delete(); expq_b.delete();
    end
    check({tag, "_nwords"}, 64'(oq.size()), 64'(eq.size()));
    n = (oq.size() < eq.size()) ? oq.size() : eq.size();
    for (int k = 0; k < n; k++) check({tag, "_word"}, 64'(oq[k]), 64'(eq[k]));
    check({tag, "_errs"}, 64'(err_seen[i]), 64'(exp_err[i]));
    check({tag, "_pkt_cnt"}, 64'(o_pkt_cnt[i]), 64'(exp_cnt[i]));
    $display("[TB] step %s inst %0d: %0d words, pkt_cnt %0d", tag, i, oq.size(), o_pkt_cnt[i]);
  endtask

  initial begin
    #1_500_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    time t0;
    for (int i = 0; i < 2; i++) begin
      in_pkt[i] = 0; exp_cnt[i] = 0; exp_err[i] = 0; err_seen[i] = 0;
      since_end[i] = 0; have_end[i] = 0;
    end
    refresh();

    // Reset values
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", 64'(o_valid[i]), 64'd0);
      check("rst_data", 64'(o_data[i]), 64'd0);
      check("rst_err", 64'(o_err[i]), 64'd0);
      check("rst_pkt_cnt", 64'(o_pkt_cnt[i]), 64'd0);
      check("rst_rd_en", 64'(rd_en[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 4-word packet preloaded, IPG=2
    t0 = $time;
    push(0, mkw(0, 1, 32'hA0A0_0000));
    push(0, mkw(0, 0, 32'hA1A1_0001));
    push(0, mkw(0, 0, 32'hA2A2_0002));
    push(0, mkw(1, 0, 32'hA3A3_0003));
    drain(0, 100);
    check("p4_latency", 64'(out_time(0, 0)), 64'(t0 + 10));
    for (int k = 1; k < 4; k++)
      check("p4_consecutive", 64'(out_time(0, k) - out_time(0, 0)), 64'(10 * k));
    check_streams(0, "p4");

    // Two single-word packets, IPG=2: exactly two idle cycles between
    push(0, mkw(1, 1, 32'h0000_5151));
    push(0, mkw(1, 1, 32'h0000_5252));
    drain(0, 100);
    check("b2b_ipg2_spacing", 64'(out_time(0, 1) - out_time(0, 0)), 64'(10 * (IPG_A + 1)));
    check_streams(0, "b2b_ipg2");

    // Same with IPG=0: consecutive cycles
    push(1, mkw(1, 1, 32'h0000_6161));
    push(1, mkw(1, 1, 32'h0000_6262));
    drain(1, 100);
    check("b2b_ipg0_spacing", 64'(out_time(1, 1) - out_time(1, 0)), 64'd10);
    check_streams(1, "b2b_ipg0");

    // Underrun after 2 of 4 words for 3 cycles
    push(0, mkw(0, 1, 32'hC0C0_0000));
    push(0, mkw(0, 0, 32'hC1C1_0001));
    repeat (5) @(negedge clk);
    push(0, mkw(0, 0, 32'hC2C2_0002));
    push(0, mkw(1, 0, 32'hC3C3_0003));
    drain(0, 100);
    check("underrun_hole", 64'(out_time(0, 2) - out_time(0, 1)), 64'd40);
    check_streams(0, "underrun");

    // Non-start word in IDLE
    push(0, mkw(0, 0, 32'h0000_DEAD));
    drain(0, 100);
    check_streams(0, "stray_idle");

    // Start during TX
    push(0, mkw(0, 1, 32'hE0E0_0000));
    push(0, mkw(0, 0, 32'hE1E1_0001));
    push(0, mkw(0, 1, 32'hE2E2_0002));
    push(0, mkw(1, 0, 32'hE3E3_0003));
    drain(0, 100);
    check_streams(0, "start_in_tx");

    // Reset mid-packet
    push(0, mkw(0, 1, 32'hF0F0_0000));
    push(0, mkw(0, 0, 32'hF1F1_0001));
    drain(0, 100);
    check_streams(0, "pre_reset");
    @(posedge clk);
    #1 rstn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", 64'(o_valid[0]), 64'd0);
    check("mid_rst_pkt_cnt", 64'(o_pkt_cnt[0]), 64'd0);
    @(negedge clk);
    push(0, mkw(0, 0, 32'hF2F2_0002));
    push(0, mkw(1, 0, 32'hF3F3_0003));
    push(0, mkw(0, 1, 32'h9090_0000));
    push(0, mkw(1, 0, 32'h9191_0001));
    repeat (2) @(negedge clk);
    check("mid_rst_rd_en", 64'(rd_en[0]), 64'd0);
    check("mid_rst_data", 64'(o_data[0]), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    drain(0, 100);
    check_streams(0, "post_reset");
    check_streams(1, "post_reset");

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) != 0)
          push(i, mkw(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom));
      end
    end
    drain(0, 2000);
    drain(1, 2000);
    check_streams(0, "random");
    check_streams(1, "random");

    // Counter wrap on the IPG=0 instance
    @(posedge clk);
    #1 rstn = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 65535; k++) push(1, mkw(1, 1, 32'(k)));
    drain(1, 70000);
    check("wrap_at_ffff", 64'(o_pkt_cnt[1]), 64'hFFFF);
    push(1, mkw(1, 1, 32'h0001_0000));
    drain(1, 100);
    check("wrap_to_zero", 64'(o_pkt_cnt[1]), 64'd0);
    check_streams(1, "wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
